ram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the 32x32 single-port RAM. It lets two requesters share the RAM, for example an instruction-fetch unit and a load/store unit. It serialises their read/write requests into single-cycle RAM accesses. It drives the RAM's chip_select, we, address and data_in, and returns read data with a one-cycle ack pulse to the requester that was served.

---
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer letting two requesters share one
// single-port RAM; one registered access per 3-cycle IDLE/ACCESS/ACK round.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t state, state_nx;
  logic   last_grant;
  logic   gnt;
  logic   pick;
  logic   any_req;

  assign any_req = req0 | req1;
  // On a tie the port that did not win last time goes next
  assign pick    = (req0 & req1) ? ~last_grant : req1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      ram_cs     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= pick;
            last_grant <= pick;
            ram_cs     <= 1'b1;
            ram_we     <= pick ? we1 : we0;
            ram_addr   <= pick ? addr1 : addr0;
            ram_wdata  <= pick ? wdata1 : wdata0;
          end else begin
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
          end
        end
        ACCESS: begin
          ram_cs <= 1'b0;
          ram_we <= 1'b0;
          ack0   <= ~gnt;
          ack1   <= gnt;
          // RAM produced read data at this cycle's negedge
          if (!ram_we) begin
            if (gnt) rdata1 <= ram_rdata;
            else     rdata0 <= ram_rdata;
          end
        end
        ACK: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: negedge RAM model, transaction-level
// round-robin reference, and a monitor that checks every ack.
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, we0, ack0;
  logic [4:0]  addr0;
  logic [31:0] wdata0, rdata0;
  logic        req1, we1, ack1;
  logic [4:0]  addr1;
  logic [31:0] wdata1, rdata1;
  logic        ram_cs, ram_we, busy;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  ram_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // external RAM: samples on negedge
  logic [31:0] mem [0:31];
  always @(negedge clock) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          ack_times[$];
  logic [31:0] ref_mem [0:31];
  bit          model_last;
  int          checks;
  int          errors;
  int          cyc;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // monitor
  always @(negedge clock) begin
    if (!reset) begin
      check("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
      check("we_without_cs", {31'b0, ram_we & ~ram_cs}, 32'd0);
      if (ack0 || ack1) begin
        ack_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ack: got ack0=%b ack1=%b expected none",
                   ack0, ack1);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_port", {31'b0, ack1}, {31'b0, mon_e.port});
          if (!mon_e.we)
            check("read_data", mon_e.port ? rdata1 : rdata0, mon_e.data);
        end
      end
    end
  end

  // port p issues n accesses, holding req until its n-th ack
  task automatic run_round(input int n0, input bit w0, input logic [4:0] a0,
                           input logic [31:0] d0, input int n1, input bit w1,
                           input logic [4:0] a1, input logic [31:0] d1);
    int p0, p1, c0, c1, t;
    bit pk, first, fp, fw;
    logic [4:0]  fa, a;
    logic [31:0] fd, d;
    bit w;
    exp_t e;
    p0 = n0; p1 = n1; first = 1'b1;
    fp = 0; fw = 0; fa = '0; fd = '0;
    while (p0 > 0 || p1 > 0) begin
      if (p0 > 0 && p1 > 0) pk = ~model_last;
      else                  pk = (p1 > 0);
      model_last = pk;
      if (pk) begin p1--; w = w1; a = a1; d = d1; end
      else    begin p0--; w = w0; a = a0; d = d0; end
      if (first) begin fp = pk; fw = w; fa = a; fd = d; first = 1'b0; end
      if (w) ref_mem[a] = d;
      e.port = pk; e.we = w; e.data = w ? 32'd0 : ref_mem[a];
      exp_q.push_back(e);
    end
    req0 = (n0 > 0); we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = (n1 > 0); we1 = w1; addr1 = a1; wdata1 = d1;
    c0 = 0; c1 = 0; t = 0;
    while ((req0 || req1) && t < 100) begin
      @(negedge clock);
      if (ack0) c0++;
      if (ack1) c1++;
      @(posedge clock);
      #1;
      if (t == 0) begin
        check("access_cs", {31'b0, ram_cs}, 32'd1);
        check("access_we", {31'b0, ram_we}, {31'b0, fw});
        check("access_addr", {27'b0, ram_addr}, {27'b0, fa});
        check("access_wdata", ram_wdata, fd);
      end else if (t == 1) begin
        check("ack_cs_low", {31'b0, ram_cs}, 32'd0);
        check("ack_busy", {31'b0, busy}, 32'd1);
        check("ack_pulse", {30'b0, ack1, ack0}, fp ? 32'd2 : 32'd1);
      end else if (t == 2) begin
        check("idle_busy", {31'b0, busy}, 32'd0);
      end
      if (c0 >= n0) req0 = 1'b0;
      if (c1 >= n1) req1 = 1'b0;
      t++;
    end
    if (req0 || req1) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: got acks %0d/%0d expected %0d/%0d",
               c0, c1, n0, n1);
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; model_last = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_rdata = '0;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_cs", {31'b0, ram_cs}, 32'd0);
    check("rst_we", {31'b0, ram_we}, 32'd0);
    check("rst_addr", {27'b0, ram_addr}, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_acks", {30'b0, ack1, ack0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    run_round(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, 32'd0);
    run_round(0, 0, 5'd0, 32'd0, 1, 0, 5'd5, 32'd0);
    @(posedge clock);
    #1;
    check("rdata1_hold", rdata1, 32'hDEADBEEF);
    check("rdata0_untouched", rdata0, 32'd0);

    run_round(2, 1, 5'd0, 32'h11111111, 2, 1, 5'd31, 32'h22222222);
    run_round(1, 0, 5'd0, 32'd0, 1, 0, 5'd31, 32'd0);

    ack_times.delete();
    run_round(3, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    check("tput_acks", ack_times.size(), 32'd3);
    if (ack_times.size() == 3) begin
      check("tput_gap1", ack_times[1] - ack_times[0], 32'd3);
      check("tput_gap2", ack_times[2] - ack_times[1], 32'd3);
    end

    run_round(1, 1, 5'd7, 32'h0000ABCD, 0, 0, 5'd0, 32'd0);
    req0 = 1; we0 = 1; addr0 = 5'd7; wdata0 = 32'hFFFFFFFF;
    @(posedge clock);
    #1;
    check("abort_access_cs", {31'b0, ram_cs}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_cs", {31'b0, ram_cs}, 32'd0);
    check("abort_we", {31'b0, ram_we}, 32'd0);
    check("abort_addr", {27'b0, ram_addr}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_acks", {30'b0, ack1, ack0}, 32'd0);
    check("abort_rdata1", rdata1, 32'd0);
    req0 = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_last = 1'b1;
    run_round(1, 0, 5'd7, 32'd0, 0, 0, 5'd0, 32'd0);

    repeat (10) begin
      @(posedge clock);
      #1;
      check("idle_quiet", {28'b0, ram_cs, ram_we, busy, ack0 | ack1}, 32'd0);
    end

    for (int r = 0; r < 30; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      run_round(n0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, n1, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom);
    end

    repeat (3) @(posedge clock);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
